// File: rtl/core_scoreboard.sv
// Issue-stage hazard controller: pending-write bitmaps for the integer and FP
// register files plus the occupancy sequencer for the shared iterative FP unit.
// Optional feature macro: SCB_WB_BYPASS_EN (same-cycle writeback masks hazards).
module core_scoreboard #(
  parameter int LONG_LAT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ISSUE_REQ,
  input  logic [4:0]  RS1_NUM,
  input  logic [4:0]  RS2_NUM,
  input  logic [4:0]  RD_NUM,
  input  logic        RS1_USE,
  input  logic        RS2_USE,
  input  logic        RS1_FP,
  input  logic        RS2_FP,
  input  logic        RD_WE,
  input  logic        RD_FP,
  input  logic        LONG_OP,
  input  logic        FLUSH,
  input  logic        WB_INT_VALID,
  input  logic [4:0]  WB_INT_NUM,
  input  logic        WB_FP_VALID,
  input  logic [4:0]  WB_FP_NUM,
  output logic        ISSUE_GNT,
  output logic        STALL,
  output logic        LONG_START,
  output logic        LONG_BUSY,
  output logic [31:0] PEND_INT,
  output logic [31:0] PEND_FP
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_long_busy;
  logic [31:0]      r_pend_int;
  logic [31:0]      r_pend_fp;

  logic [31:0] w_clr_int, w_clr_fp;
  logic [31:0] w_set_int, w_set_fp;
  logic [31:0] w_haz_int, w_haz_fp;
  logic        w_hazard;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no latch is inferred.
    w_clr_int = '0;
    w_clr_fp  = '0;
    if (WB_INT_VALID) w_clr_int[WB_INT_NUM] = 1'b1;
    if (WB_FP_VALID)  w_clr_fp[WB_FP_NUM]   = 1'b1;
  end

`ifdef SCB_WB_BYPASS_EN
  assign w_haz_int = {r_pend_int[31:1] & ~w_clr_int[31:1], 1'b0};
  assign w_haz_fp  = r_pend_fp & ~w_clr_fp;
`else
  assign w_haz_int = {r_pend_int[31:1], 1'b0};
  assign w_haz_fp  = r_pend_fp;
`endif

  assign w_hazard = (RS1_USE & (RS1_FP ? w_haz_fp[RS1_NUM] : w_haz_int[RS1_NUM]))
                  | (RS2_USE & (RS2_FP ? w_haz_fp[RS2_NUM] : w_haz_int[RS2_NUM]))
                  | (RD_WE   & (RD_FP  ? w_haz_fp[RD_NUM]  : w_haz_int[RD_NUM]))
                  | (LONG_OP & r_long_busy);

  assign ISSUE_GNT  = ISSUE_REQ & ~FLUSH & ~w_hazard;
  assign STALL      = ISSUE_REQ & ~FLUSH &  w_hazard;
  assign LONG_START = ISSUE_GNT & LONG_OP;

  // x0 is hardwired zero, so a write to it never becomes outstanding.
  always_comb begin
    w_set_int = '0;
    w_set_fp  = '0;
    if (ISSUE_GNT && RD_WE) begin
      if (RD_FP)                w_set_fp[RD_NUM]  = 1'b1;
      else if (RD_NUM != 5'd0)  w_set_int[RD_NUM] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!RST_N) begin
      r_pend_int <= '0;
      r_pend_fp  <= '0;
    end else begin
      // Set is OR-ed after the clear so a new write outranks a same-cycle writeback.
      r_pend_int <= (r_pend_int & ~w_clr_int) | w_set_int;
      r_pend_fp  <= (r_pend_fp  & ~w_clr_fp)  | w_set_fp;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_long_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LONG_START) begin
            r_state     <= ST_BUSY;
            r_cnt       <= CNT_W'(LONG_LAT - 1);
            r_long_busy <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state     <= ST_IDLE;
            r_long_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_long_busy <= 1'b0;
        end
      endcase
    end
  end

  assign LONG_BUSY = r_long_busy;
  assign PEND_INT  = r_pend_int;
  assign PEND_FP   = r_pend_fp;

endmodule

// File: tb/tb_core_scoreboard.sv
// Self-checking bench for core_scoreboard: directed scenarios followed by
// random traffic, all compared against a behavioural scoreboard model.
module tb_core_scoreboard;

  localparam int LONG_LAT = 16;
  localparam int CNT_W    = 5;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ISSUE_REQ;
  logic [4:0]  RS1_NUM, RS2_NUM, RD_NUM;
  logic        RS1_USE, RS2_USE, RS1_FP, RS2_FP;
  logic        RD_WE, RD_FP, LONG_OP, FLUSH;
  logic        WB_INT_VALID, WB_FP_VALID;
  logic [4:0]  WB_INT_NUM, WB_FP_NUM;
  logic        ISSUE_GNT, STALL, LONG_START, LONG_BUSY;
  logic [31:0] PEND_INT, PEND_FP;

  core_scoreboard #(.LONG_LAT(LONG_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .ISSUE_REQ(ISSUE_REQ),
    .RS1_NUM(RS1_NUM), .RS2_NUM(RS2_NUM), .RD_NUM(RD_NUM),
    .RS1_USE(RS1_USE), .RS2_USE(RS2_USE), .RS1_FP(RS1_FP), .RS2_FP(RS2_FP),
    .RD_WE(RD_WE), .RD_FP(RD_FP), .LONG_OP(LONG_OP), .FLUSH(FLUSH),
    .WB_INT_VALID(WB_INT_VALID), .WB_INT_NUM(WB_INT_NUM),
    .WB_FP_VALID(WB_FP_VALID), .WB_FP_NUM(WB_FP_NUM),
    .ISSUE_GNT(ISSUE_GNT), .STALL(STALL), .LONG_START(LONG_START),
    .LONG_BUSY(LONG_BUSY), .PEND_INT(PEND_INT), .PEND_FP(PEND_FP)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one flag per architectural register, plus cycles left on the FP unit.
  bit m_pint[32];
  bit m_pfp[32];
  int m_busy_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input bit fp, input logic [4:0] num);
    bit p;
    p = fp ? m_pfp[num] : (num != 5'd0 && m_pint[num]);
`ifdef SCB_WB_BYPASS_EN
    if (fp && WB_FP_VALID && WB_FP_NUM == num) p = 1'b0;
    if (!fp && WB_INT_VALID && WB_INT_NUM == num) p = 1'b0;
`endif
    return p;
  endfunction

  function automatic bit m_hazard();
    return (RS1_USE && m_pend(RS1_FP, RS1_NUM)) || (RS2_USE && m_pend(RS2_FP, RS2_NUM))
        || (RD_WE && m_pend(RD_FP, RD_NUM)) || (LONG_OP && m_busy_left > 0);
  endfunction

  function automatic bit m_gnt();
    return ISSUE_REQ && !FLUSH && !m_hazard();
  endfunction

  function automatic logic [31:0] m_vec_int();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pint[i];
    return v;
  endfunction

  function automatic logic [31:0] m_vec_fp();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pfp[i];
    return v;
  endfunction

  // Compare at the falling edge, advance the model, then return just after the rising edge.
  task automatic step(input bit chk);
    bit g;
    @(negedge CLK);
    if (chk) begin
      check("gnt",      ISSUE_GNT,  m_gnt());
      check("stall",    STALL,      ISSUE_REQ && !FLUSH && m_hazard());
      check("start",    LONG_START, m_gnt() && LONG_OP);
      check("busy",     LONG_BUSY,  m_busy_left > 0);
      check("pend_int", PEND_INT,   m_vec_int());
      check("pend_fp",  PEND_FP,    m_vec_fp());
    end
    if (!RST_N) begin
      for (int i = 0; i < 32; i++) begin
        m_pint[i] = 1'b0;
        m_pfp[i]  = 1'b0;
      end
      m_busy_left = 0;
    end else begin
      g = m_gnt();
      if (WB_INT_VALID) m_pint[WB_INT_NUM] = 1'b0;
      if (WB_FP_VALID)  m_pfp[WB_FP_NUM]   = 1'b0;
      if (g && RD_WE) begin
        if (RD_FP)                m_pfp[RD_NUM]  = 1'b1;
        else if (RD_NUM != 5'd0)  m_pint[RD_NUM] = 1'b1;
      end
      if (g && LONG_OP)        m_busy_left = LONG_LAT;
      else if (m_busy_left > 0) m_busy_left--;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ISSUE_REQ = 0; RS1_NUM = 0; RS2_NUM = 0; RD_NUM = 0;
    RS1_USE = 0; RS2_USE = 0; RS1_FP = 0; RS2_FP = 0;
    RD_WE = 0; RD_FP = 0; LONG_OP = 0; FLUSH = 0;
    WB_INT_VALID = 0; WB_INT_NUM = 0; WB_FP_VALID = 0; WB_FP_NUM = 0;
  endtask

  task automatic req(input logic [4:0] rs1, input bit u1, input bit f1,
                     input logic [4:0] rd, input bit we, input bit fp, input bit lop);
    ISSUE_REQ = 1; RS1_NUM = rs1; RS1_USE = u1; RS1_FP = f1;
    RS2_NUM = 0; RS2_USE = 0; RS2_FP = 0;
    RD_NUM = rd; RD_WE = we; RD_FP = fp; LONG_OP = lop; FLUSH = 0;
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    m_busy_left = 0;
    step(0);
    step(0);
    RST_N = 1'b1;
    #1;
    check("reset_pend_int", PEND_INT, 32'h0);
    check("reset_pend_fp",  PEND_FP,  32'h0);
    check("reset_busy",     LONG_BUSY, 1'b0);

    // RAW on x5 resolved by writeback
    idle(); req(0, 0, 0, 5, 1, 0, 0); #1;
    check("t1_first_gnt", ISSUE_GNT, 1'b1);
    step(1);
    check("t1_x5_pending", PEND_INT[5], 1'b1);
    req(5, 1, 0, 0, 0, 0, 0); #1;
    check("t1_stall", STALL, 1'b1);
    check("t1_no_gnt", ISSUE_GNT, 1'b0);
    step(1);
    WB_INT_VALID = 1; WB_INT_NUM = 5; #1;
`ifdef SCB_WB_BYPASS_EN
    check("t1_wb_cycle_gnt", ISSUE_GNT, 1'b1);
`else
    check("t1_wb_cycle_gnt", ISSUE_GNT, 1'b0);
`endif
    step(1);
    WB_INT_VALID = 0; #1;
    check("t1_after_wb_gnt", ISSUE_GNT, 1'b1);
    step(1);

    // x0 is never pending
    idle(); req(0, 0, 0, 0, 1, 0, 0); step(1);
    check("t2_x0_not_set", PEND_INT, 32'h0);
    req(0, 1, 0, 0, 0, 0, 0); #1;
    check("t2_x0_no_stall", STALL, 1'b0);
    step(1);

    // Independent integer / FP files with the same index
    idle(); req(0, 0, 0, 3, 1, 0, 0); step(1);
    req(0, 0, 0, 3, 1, 1, 0); step(1);
    idle(); WB_FP_VALID = 1; WB_FP_NUM = 3; step(1);
    check("t3_fp3_clear", PEND_FP[3], 1'b0);
    check("t3_int3_kept", PEND_INT[3], 1'b1);
    idle(); req(3, 1, 1, 0, 0, 0, 0); #1;
    check("t3_fp_src_gnt", ISSUE_GNT, 1'b1);
    step(1);
    req(3, 1, 0, 0, 0, 0, 0); #1;
    check("t3_int_src_stall", STALL, 1'b1);
    step(1);
    idle(); WB_INT_VALID = 1; WB_INT_NUM = 3; step(1);

    // Set wins over same-cycle writeback
    idle(); req(0, 0, 0, 7, 1, 1, 0); WB_FP_VALID = 1; WB_FP_NUM = 7; step(1);
    check("t5_set_wins", PEND_FP[7], 1'b1);

    // Flush suppresses grant and stall
    idle(); req(0, 0, 0, 9, 1, 0, 0); FLUSH = 1; #1;
    check("t6_flush_gnt", ISSUE_GNT, 1'b0);
    check("t6_flush_stall", STALL, 1'b0);
    step(1);
    check("t6_flush_no_set", PEND_INT[9], 1'b0);

    // Iterative FP unit occupancy
    idle(); req(0, 0, 0, 0, 0, 0, 1); #1;
    check("t4_start", LONG_START, 1'b1);
    step(1);
    for (int i = 0; i < LONG_LAT; i++) begin
      check($sformatf("t4_busy_%0d", i), LONG_BUSY, 1'b1);
      check($sformatf("t4_stall_%0d", i), STALL, 1'b1);
      step(1);
    end
    check("t4_busy_done", LONG_BUSY, 1'b0);
    check("t4_regrant", LONG_START, 1'b1);
    step(1);

    // Reset during BUSY clears everything (f7 is still pending here)
    idle(); step(1); step(1);
    check("t6_busy_before_rst", LONG_BUSY, 1'b1);
    RST_N = 1'b0; step(1);
    check("t6_rst_busy", LONG_BUSY, 1'b0);
    check("t6_rst_pend_fp", PEND_FP, 32'h0);
    check("t6_rst_pend_int", PEND_INT, 32'h0);
    RST_N = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      ISSUE_REQ    = ($urandom_range(0, 3) != 0);
      RS1_NUM      = 5'($urandom_range(0, 7));
      RS2_NUM      = 5'($urandom_range(0, 7));
      RD_NUM       = 5'($urandom_range(0, 7));
      RS1_USE      = 1'($urandom);
      RS2_USE      = 1'($urandom);
      RS1_FP       = 1'($urandom);
      RS2_FP       = 1'($urandom);
      RD_WE        = 1'($urandom);
      RD_FP        = 1'($urandom);
      LONG_OP      = ($urandom_range(0, 9) == 0);
      FLUSH        = ($urandom_range(0, 7) == 0);
      WB_INT_VALID = ($urandom_range(0, 2) == 0);
      WB_INT_NUM   = 5'($urandom_range(0, 7));
      WB_FP_VALID  = ($urandom_range(0, 2) == 0);
      WB_FP_NUM    = 5'($urandom_range(0, 7));
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
